// File: rtl/piso_stream.sv
// Parallel-in serial-out shifter with a valid/ready load port and a one-word hold buffer.
// A strobe (en_i) paces the bits; back-to-back words serialise with no idle bit in between.
module piso_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  input  logic             en_i,
  output logic             data_o,
  output logic             busy_o,
  output logic             last_o,
  output logic             done_o
);

  localparam int unsigned   CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, hold_q, shifted;
  logic [CW-1:0]    cnt_q;
  logic             hold_full_q;
  logic             done_q;
  logic             accept;
  logic             final_edge;

  always_comb begin
    accept     = valid_i && !hold_full_q;
    final_edge = (state_q == SHIFT) && en_i && (cnt_q == CNT_LAST);
    shifted    = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = SHIFT;
      SHIFT: if (final_edge && !hold_full_q && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // On the final-bit edge the held word takes priority over a fresh input word;
  // ready_o is low whenever hold is full, so the two can never collide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= final_edge;
      if (state_q == IDLE) begin
        if (accept) begin
          shreg_q <= data_i;
          cnt_q   <= '0;
        end
      end else if (final_edge) begin
        cnt_q <= '0;
        if (hold_full_q) begin
          shreg_q     <= hold_q;
          hold_full_q <= 1'b0;
        end else if (accept) begin
          shreg_q <= data_i;
        end else begin
          shreg_q <= '0;
        end
      end else begin
        if (en_i) begin
          shreg_q <= shifted;
          cnt_q   <= cnt_q + 1'b1;
        end
        if (accept) begin
          hold_q      <= data_i;
          hold_full_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy_o  = (state_q == SHIFT);
    last_o  = busy_o && (cnt_q == CNT_LAST);
    data_o  = busy_o ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : 1'b0;
    ready_o = !hold_full_q;
    done_o  = done_q;
  end

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream: an MSB-first and an LSB-first instance share one stimulus stream.
module tb_piso_stream;

  logic       clk = 1'b0;
  logic       rst, valid, en;
  logic [7:0] data;
  logic       ready_m, data_m, busy_m, last_m, done_m;
  logic       ready_l, data_l, busy_l, last_l, done_l;
  int         total = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  piso_stream #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data), .ready_o(ready_m),
    .en_i(en), .data_o(data_m), .busy_o(busy_m), .last_o(last_m), .done_o(done_m)
  );

  piso_stream #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data), .ready_o(ready_l),
    .en_i(en), .data_o(data_l), .busy_o(busy_l), .last_o(last_l), .done_o(done_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  wa5;
    logic [7:0]  wc1;
    logic [7:0]  wf0;
    logic [15:0] w16;
    wa5 = 8'hA5;
    wc1 = 8'hC1;
    wf0 = 8'hF0;
    w16 = 16'hA53C;

    // 1. Reset with a word offered
    rst = 1'b1; valid = 1'b1; data = 8'hFF; en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_data", data_m, 1'b0);
      chk("rst_busy", busy_m, 1'b0);
      chk("rst_last", last_m, 1'b0);
      chk("rst_done", done_m, 1'b0);
    end
    rst = 1'b0; valid = 1'b0;
    chk("rst_ready", ready_m, 1'b1);
    tick();
    chk("rst_noload", busy_m, 1'b0);

    // 2. Single word A5, MSB first
    valid = 1'b1; data = 8'hA5;
    tick();
    valid = 1'b0; data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk("single_bit", data_m, wa5[7-i]);
      chk("single_last", last_m, (i == 7));
      chk("single_busy", busy_m, 1'b1);
      chk("single_done", done_m, 1'b0);
      tick();
    end
    chk("single_done_pulse", done_m, 1'b1);
    chk("single_busy_drop", busy_m, 1'b0);
    chk("single_idle_data", data_m, 1'b0);
    tick();
    chk("single_done_clear", done_m, 1'b0);

    // 3. Back-to-back A5 then 3C through the hold buffer
    valid = 1'b1; data = 8'hA5;
    tick();
    data = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      chk("b2b_bit", data_m, w16[15-i]);
      chk("b2b_ready", ready_m, (i == 0 || i >= 8));
      chk("b2b_done", done_m, (i == 8));
      chk("b2b_last", last_m, (i == 7 || i == 15));
      chk("b2b_busy", busy_m, 1'b1);
      tick();
      if (i == 0) begin
        valid = 1'b0; data = 8'h00;
      end
    end
    chk("b2b_done2", done_m, 1'b1);
    chk("b2b_busy_drop", busy_m, 1'b0);
    tick();

    // 4. Enable every third cycle
    valid = 1'b1; data = 8'hA5; en = 1'b0;
    tick();
    valid = 1'b0; data = 8'h00;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 3; k++) begin
        en = (k == 2);
        chk("pace_bit", data_m, wa5[7-b]);
        chk("pace_last", last_m, (b == 7));
        chk("pace_done", done_m, 1'b0);
        tick();
      end
    end
    en = 1'b1;
    chk("pace_done_pulse", done_m, 1'b1);
    chk("pace_busy_drop", busy_m, 1'b0);
    tick();
    chk("pace_single_done", done_m, 1'b0);

    // 5. LSB-first instance with C1
    valid = 1'b1; data = 8'hC1;
    tick();
    valid = 1'b0; data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk("lsb_bit", data_l, wc1[i]);
      chk("lsb_last", last_l, (i == 7));
      tick();
    end
    chk("lsb_done", done_l, 1'b1);
    chk("lsb_busy_drop", busy_l, 1'b0);
    tick();

    // 6. Reset mid-word with a held word, then a clean word
    valid = 1'b1; data = 8'hA5;
    tick();
    data = 8'h3C;
    tick();
    valid = 1'b0; data = 8'h00;
    chk("mid_hold_full", ready_m, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_data", data_m, 1'b0);
    chk("mid_busy", busy_m, 1'b0);
    chk("mid_last", last_m, 1'b0);
    chk("mid_done", done_m, 1'b0);
    chk("mid_ready", ready_m, 1'b1);
    tick();
    chk("mid_no_done", done_m, 1'b0);
    chk("mid_stay_idle", busy_m, 1'b0);
    valid = 1'b1; data = 8'hF0;
    tick();
    valid = 1'b0; data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk("mid_f0_bit", data_m, wf0[7-i]);
      chk("mid_f0_last", last_m, (i == 7));
      chk("mid_f0_done", done_m, 1'b0);
      tick();
    end
    chk("mid_f0_done_pulse", done_m, 1'b1);
    chk("mid_no_residue", busy_m, 1'b0);
    tick();
    chk("mid_final_done_clear", done_m, 1'b0);
    chk("mid_final_idle", busy_m, 1'b0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in serial-out shift register with a valid/ready load handshake and a one-word holding buffer.
- Back-to-back words serialise with no idle bit between them.
- Bit rate is set by a shift-enable strobe, so a baud or tick generator can pace it.
- Sits between a word producer (FIFO or register block) and a serial line driver.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = data_i[WIDTH-1] is sent first; 0 = data_i[0] is sent first.

Ports:
- clk_i  input  1  single clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  data_i holds a word to load.
- data_i  input  WIDTH  parallel word; sampled when valid_i && ready_o.
- ready_o  input-side handshake, output  1  block can accept a word this cycle.
- en_i  input  1  shift strobe; one bit advances per rising edge with en_i=1.
- data_o  output  1  serial bit currently presented.
- busy_o  output  1  a word is being serialised.
- last_o  output  1  data_o carries the final bit of the current word.
- done_o  output  1  one-cycle pulse after a word's final bit completes.

Behaviour:
- Reset (synchronous, rst_i=1 at edge):
  - State=IDLE, shifter=0, bit counter=0, hold buffer empty.
  - data_o=0, busy_o=0, last_o=0, done_o=0, ready_o=1 in the following cycle.
- Reset mid-word: the partial word and any held word are discarded. No done_o is issued.
- States:
  - IDLE: shifter empty.
  - SHIFT: serialising; bit counter cnt runs 0..WIDTH-1.
- ready_o = !hold_full. This is a combinational function of registered state only; there is no path from valid_i.
- Accept happens at an edge with valid_i && ready_o:
  - In IDLE, or at the edge completing the final bit: the word loads straight into the shifter (bypasses hold).
  - State=SHIFT, cnt=0.
  - The first bit appears on data_o in the cycle after the accept edge.
  - Otherwise (in SHIFT, not on the final-bit edge): the word goes into hold, hold_full=1.
- In SHIFT:
  - data_o = shifter[WIDTH-1] if MSB_FIRST, else shifter[0].
  - Each edge with en_i=1 shifts toward the output end (zero fill) and increments cnt.
  - With en_i=0, the shifter and cnt hold; data_o is stable for any number of cycles.
- Final-bit edge (en_i=1 and cnt==WIDTH-1), in priority order:
  - (a) hold_full: the hold word loads into the shifter, cnt=0, hold_full=0, stay in SHIFT.
  - (b) else an accepted input word loads directly, stay in SHIFT.
  - (c) else go to IDLE.
- done_o pulses in the cycle after every final-bit edge, in all three cases.
- last_o = busy_o && cnt==WIDTH-1.
- busy_o = (state==SHIFT).
- data_o=0 whenever in IDLE.
- Throughput: with en_i tied high and valid_i continuously high, exactly one bit per cycle, no gaps. ready_o toggles as hold fills and drains.
- Data_i is ignored unless accepted. A word is never accepted while hold_full.

Test Plan:
- 1. Reset: drive rst_i=1 for 2 cycles with valid_i=1, data_i=8'hFF -> data_o=0, busy_o=0, last_o=0, done_o=0 throughout; ready_o=1 after release; nothing loaded.
- 2. Single word (WIDTH=8, MSB_FIRST=1, en_i=1): accept 8'hA5 -> data_o = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; last_o high on the 8th only; done_o high on the next cycle; busy_o drops with it.
- 3. Back-to-back: hold valid_i with 8'hA5 then 8'h3C -> 8'h3C lands in hold; ready_o=0 until the A5 final-bit edge; 16 contiguous bits 10100101 00111100, no gap; done_o pulses twice, 8 cycles apart.
- 4. Enable pacing: en_i high every 3rd cycle, word 8'hA5 -> each bit held exactly 3 cycles; last_o held 3 cycles; a single done_o pulse.
- 5. LSB-first instance (MSB_FIRST=0): accept 8'hC1 -> data_o = 1,0,0,0,0,0,1,1.
- 6. Mid-word reset: word 8'hA5 plus held 8'h3C, assert rst_i after 3 bits -> all outputs 0 the next cycle, ready_o=1, no done_o; then accept 8'hF0 -> full 1,1,1,1,0,0,0,0 with no residue from either discarded word.
